sitcp_tcp_session_ctrl: RTL and testbench

Sequences the TCP connection handshake of the SiTCP core and gates the user byte stream into its TX FIFO.
- Drives OPEN_REQ.
- Retries failed client-mode opens after a millisecond backoff, with a bounded retry count.
- Completes the close handshake (CLOSE_REQ/CLOSE_ACK) only after the last accepted user byte has been written.
- Sits between the user application and the SiTCP core in the CLK domain.

---
 rtl/sitcp_tcp_session_ctrl.sv | 144 ++++++++++++++
 tb/tb_sitcp_tcp_session_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sitcp_tcp_session_ctrl.sv
// TCP session sequencer for the SiTCP core. It handles open with retry and backoff,
// close handshake with TX drain, and gates the user byte stream into the core TX FIFO.
module sitcp_tcp_session_ctrl #(
  parameter int unsigned RETRY_MS  = 100,
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TIM_1MS,
  input  logic       CONNECT,
  input  logic       SiTCP_RST,
  output logic       OPEN_REQ,
  input  logic       MAIN_OPEN_ACK,
  input  logic       TCP_OPEN_ERROR,
  input  logic       CLOSE_REQ,
  output logic       CLOSE_ACK,
  input  logic       US_TX_VALID,
  input  logic [7:0] US_TX_DATA,
  output logic       US_TX_READY,
  input  logic       TX_FULL,
  output logic       TX_WR,
  output logic [7:0] TX_DATA,
  output logic       SESSION_UP,
  output logic       RETRY_EXHAUSTED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StOpening = 3'd1,
    StEstab   = 3'd2,
    StDrain   = 3'd3,
    StClosing = 3'd4,
    StBackoff = 3'd5,
    StFail    = 3'd6
  } state_e;

  localparam logic [16:0] RetryMsW  = 17'(RETRY_MS);
  localparam logic [7:0]  MaxRetryW = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [7:0]  retry_cnt_q, retry_cnt_d, retry_inc;
  logic        open_req_q, open_req_d;
  logic        close_ack_q, session_up_q, retry_exh_q;
  logic        tx_wr_q;
  logic [7:0]  tx_data_q;
  logic        tx_hs;

  // Ready is gated by both resets so no byte is accepted only to be discarded by the clear.
  assign US_TX_READY = RSTn & ~SiTCP_RST & (state_q == StEstab) & ~TX_FULL;
  assign tx_hs       = US_TX_VALID & US_TX_READY;

  assign retry_inc = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    ms_cnt_d    = ms_cnt_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      StIdle: begin
        if (CONNECT) state_d = StOpening;
      end
      StOpening: begin
        if (MAIN_OPEN_ACK) begin
          state_d     = StEstab;
          retry_cnt_d = 8'd0;
        end else if (TCP_OPEN_ERROR) begin
          retry_cnt_d = retry_inc;
          if ((MAX_RETRY != 0) && (retry_inc == MaxRetryW)) begin
            state_d = StFail;
          end else begin
            state_d  = StBackoff;
            ms_cnt_d = 16'd0;
          end
        end else if (!CONNECT) begin
          state_d = StIdle;
        end
      end
      StEstab: begin
        if (CLOSE_REQ)           state_d = StDrain;
        else if (!MAIN_OPEN_ACK) state_d = StIdle;
      end
      StDrain: begin
        state_d = StClosing;
      end
      StClosing: begin
        if (!CLOSE_REQ) state_d = StIdle;
      end
      StBackoff: begin
        if (!CONNECT) begin
          state_d     = StIdle;
          retry_cnt_d = 8'd0;
        end else if (TIM_1MS) begin
          if (({1'b0, ms_cnt_q} + 17'd1) == RetryMsW) state_d = StOpening;
          else                                        ms_cnt_d = ms_cnt_q + 16'd1;
        end
      end
      StFail: begin
        if (!CONNECT) begin
          state_d     = StIdle;
          retry_cnt_d = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // In ESTAB the request follows CONNECT so the user can signal a close by dropping it.
  assign open_req_d = (state_d == StOpening) | ((state_d == StEstab) & CONNECT);

  always_ff @(posedge CLK) begin
    if (!RSTn || SiTCP_RST) begin
      state_q      <= StIdle;
      ms_cnt_q     <= 16'd0;
      retry_cnt_q  <= 8'd0;
      open_req_q   <= 1'b0;
      close_ack_q  <= 1'b0;
      session_up_q <= 1'b0;
      retry_exh_q  <= 1'b0;
      tx_wr_q      <= 1'b0;
      tx_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      ms_cnt_q     <= ms_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      open_req_q   <= open_req_d;
      close_ack_q  <= (state_d == StClosing);
      session_up_q <= (state_d == StEstab);
      retry_exh_q  <= (state_d == StFail);
      tx_wr_q      <= tx_hs;
      if (tx_hs) tx_data_q <= US_TX_DATA;
    end
  end

  assign OPEN_REQ        = open_req_q;
  assign CLOSE_ACK       = close_ack_q;
  assign SESSION_UP      = session_up_q;
  assign RETRY_EXHAUSTED = retry_exh_q;
  assign TX_WR           = tx_wr_q;
  assign TX_DATA         = tx_data_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_sitcp_tcp_session_ctrl.sv
// Directed session walk-through with randomized data and timing; a negedge monitor
// predicts READY and the one-cycle TX write from the handshake rules.
module tb_sitcp_tcp_session_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn, TIM_1MS, CONNECT, SiTCP_RST, MAIN_OPEN_ACK, TCP_OPEN_ERROR, CLOSE_REQ;
  logic       US_TX_VALID, TX_FULL;
  logic [7:0] US_TX_DATA;
  logic       OPEN_REQ, CLOSE_ACK, US_TX_READY, TX_WR, SESSION_UP, RETRY_EXHAUSTED;
  logic [7:0] TX_DATA;
  logic [2:0] STATE;

  int   checks = 0;
  int   failures = 0;
  int   wr_count = 0;
  bit   in_estab = 1'b0;
  bit   exp_pending = 1'b0;
  logic [7:0] exp_byte = 8'd0;

  sitcp_tcp_session_ctrl #(.RETRY_MS(3), .MAX_RETRY(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .TIM_1MS(TIM_1MS), .CONNECT(CONNECT), .SiTCP_RST(SiTCP_RST),
    .OPEN_REQ(OPEN_REQ), .MAIN_OPEN_ACK(MAIN_OPEN_ACK), .TCP_OPEN_ERROR(TCP_OPEN_ERROR),
    .CLOSE_REQ(CLOSE_REQ), .CLOSE_ACK(CLOSE_ACK), .US_TX_VALID(US_TX_VALID),
    .US_TX_DATA(US_TX_DATA), .US_TX_READY(US_TX_READY), .TX_FULL(TX_FULL), .TX_WR(TX_WR),
    .TX_DATA(TX_DATA), .SESSION_UP(SESSION_UP), .RETRY_EXHAUSTED(RETRY_EXHAUSTED),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic oreq,
                        input logic sup, input logic cack, input logic rexh);
    chk_v({tag, "_state"}, 16'(STATE), 16'(st));
    chk_b({tag, "_open_req"}, OPEN_REQ, oreq);
    chk_b({tag, "_session_up"}, SESSION_UP, sup);
    chk_b({tag, "_close_ack"}, CLOSE_ACK, cack);
    chk_b({tag, "_retry_exh"}, RETRY_EXHAUSTED, rexh);
  endtask

  task automatic chk_zero(input string tag);
    chk_st(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_b({tag, "_tx_wr"}, TX_WR, 1'b0);
    chk_v({tag, "_tx_data"}, 16'(TX_DATA), 16'd0);
    chk_b({tag, "_ready"}, US_TX_READY, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ms_pulse();
    TIM_1MS = 1'b1;
    tick();
    TIM_1MS = 1'b0;
  endtask

  // Ready is high only in ESTAB with the FIFO not full; an accepted byte is written next cycle.
  always @(negedge CLK) begin : mon
    bit exp_ready;
    exp_ready = in_estab && (TX_FULL === 1'b0) && (RSTn === 1'b1) && (SiTCP_RST === 1'b0);
    chk_b("tx_ready", US_TX_READY, exp_ready);
    chk_b("tx_wr", TX_WR, exp_pending);
    if (exp_pending) chk_v("tx_data", 16'(TX_DATA), 16'(exp_byte));
    if (TX_WR === 1'b1) wr_count++;
    if ((RSTn !== 1'b1) || (SiTCP_RST !== 1'b0)) begin
      exp_pending = 1'b0;
    end else begin
      exp_pending = exp_ready && (US_TX_VALID === 1'b1);
      if (exp_pending) exp_byte = US_TX_DATA;
    end
  end

  initial begin
    int idx;
    int base;
    int gap;
    logic [7:0] byte_v;

    RSTn = 1'b0; TIM_1MS = 1'b0; CONNECT = 1'b0; SiTCP_RST = 1'b0; MAIN_OPEN_ACK = 1'b0;
    TCP_OPEN_ERROR = 1'b0; CLOSE_REQ = 1'b0; US_TX_VALID = 1'b0; US_TX_DATA = 8'd0;
    TX_FULL = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    RSTn = 1'b1;
    tick();
    chk_st("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Normal open, ACK five cycles after CONNECT.
    CONNECT = 1'b1;
    tick();
    chk_st("open_c1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      tick();
      chk_st("opening", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    MAIN_OPEN_ACK = 1'b1;
    tick();
    in_estab = 1'b1;
    chk_st("estab", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stream 0x00..0xFF with random VALID gaps.
    idx = 0;
    while (idx < 256) begin
      US_TX_VALID = ($urandom_range(0, 3) != 0);
      US_TX_DATA  = 8'(idx);
      tick();
      if (US_TX_VALID) idx++;
    end
    US_TX_VALID = 1'b0;
    tick();
    chk_v("stream_count", 16'(wr_count), 16'd256);

    // Backpressure: ten cycles of TX_FULL with VALID held.
    base = wr_count;
    TX_FULL = 1'b1; US_TX_VALID = 1'b1; US_TX_DATA = 8'($urandom);
    repeat (10) tick();
    chk_v("bp_no_write", 16'(wr_count), 16'(base));
    TX_FULL = 1'b0;
    idx = 0;
    while (idx < 20) begin
      US_TX_DATA  = 8'($urandom);
      US_TX_VALID = ($urandom_range(0, 1) != 0);
      TX_FULL     = ($urandom_range(0, 4) == 0);
      tick();
      if (US_TX_VALID && !TX_FULL) idx++;
    end
    US_TX_VALID = 1'b0; TX_FULL = 1'b0;
    tick();
    chk_v("bp_count", 16'(wr_count), 16'(base + 20));

    // Close with a byte handshaken in the same cycle CLOSE_REQ rises.
    US_TX_VALID = 1'b1; US_TX_DATA = 8'hA5; CLOSE_REQ = 1'b1;
    tick();
    in_estab = 1'b0; US_TX_VALID = 1'b0;
    chk_st("drain", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("drain_wr", TX_WR, 1'b1);
    chk_v("drain_data", 16'(TX_DATA), 16'h00A5);
    tick();
    chk_st("closing", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    MAIN_OPEN_ACK = 1'b0;
    tick();
    chk_st("closing_hold", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    CLOSE_REQ = 1'b0;
    tick();
    chk_st("closed", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("reopen", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // First error: OPEN_REQ low for exactly three 1 ms pulses.
    TCP_OPEN_ERROR = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b0;
    chk_st("err1", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 1; p <= 3; p++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        tick();
        chk_st("backoff_gap", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      ms_pulse();
      chk_st("backoff_ms", (p == 3) ? 3'd1 : 3'd5, p == 3, 1'b0, 1'b0, 1'b0);
    end

    // Second error exhausts the budget.
    TCP_OPEN_ERROR = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b0;
    chk_st("fail", 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    ms_pulse();
    repeat (2) tick();
    chk_st("fail_hold", 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    CONNECT = 1'b0;
    tick();
    chk_st("fail_exit", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Dropping CONNECT in BACKOFF clears the retry count.
    CONNECT = 1'b1;
    tick();
    chk_st("bo_open", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    TCP_OPEN_ERROR = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b0;
    chk_st("bo_err", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    CONNECT = 1'b0;
    tick();
    chk_st("bo_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    CONNECT = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b0;
    chk_st("bo_err_again", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) ms_pulse();
    chk_st("bo_reopen", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ACK and ERROR together: ACK wins and the count (1 so far) is cleared.
    MAIN_OPEN_ACK = 1'b1; TCP_OPEN_ERROR = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b0;
    in_estab = 1'b1;
    chk_st("ack_err", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // ACK drop aborts the session; the in-flight byte still goes out.
    byte_v = 8'($urandom);
    US_TX_VALID = 1'b1; US_TX_DATA = byte_v; MAIN_OPEN_ACK = 1'b0;
    tick();
    in_estab = 1'b0; US_TX_VALID = 1'b0;
    chk_st("abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("abort_wr", TX_WR, 1'b1);
    chk_v("abort_data", 16'(TX_DATA), 16'(byte_v));
    tick();
    chk_st("abort_reopen", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    TCP_OPEN_ERROR = 1'b1;
    tick();
    TCP_OPEN_ERROR = 1'b0;
    chk_st("cnt_cleared", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // RSTn in BACKOFF.
    ms_pulse();
    RSTn = 1'b0;
    tick();
    chk_zero("rstn_backoff");
    RSTn = 1'b1;
    tick();
    chk_st("rst_reopen", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    MAIN_OPEN_ACK = 1'b1;
    tick();
    in_estab = 1'b1;
    US_TX_VALID = 1'b1; US_TX_DATA = 8'($urandom);
    tick();
    chk_b("pending_wr", TX_WR, 1'b1);

    // SiTCP_RST in ESTAB with a write pending.
    SiTCP_RST = 1'b1;
    tick();
    in_estab = 1'b0;
    chk_zero("sitcp_rst");
    SiTCP_RST = 1'b0; US_TX_VALID = 1'b0; CONNECT = 1'b0; MAIN_OPEN_ACK = 1'b0;
    tick();
    chk_st("post_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
